sfx_sequencer: RTL and testbench

Upstream control stage for audio_engine. Converts the game logic's jump-request and death-flag levels into timed `jump` / `isdead` gate levels: fixed-length tone windows, with priority, silence gaps and lockout. Outputs drive audio_engine's `jump` and `isdead` inputs directly. A mandatory silent gap between tones lets audio_engine reload its pitch counters.

---
 rtl/sfx_sequencer.sv | 106 ++++++++++
 tb/tb_sfx_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: turns game-logic jump/death levels into timed jump/isdead
// tone gates for audio_engine, with death priority, a silent gap after each
// jump tone, and a hold-off until the death flag clears.
// Optional build macro: SFX_RETRIGGER_EN (a new jump request during a jump
// tone restarts the tone after a one-cycle drop of the gate).
module sfx_sequencer #(
  parameter int TICK_DIV    = 100000,
  parameter int JUMP_TICKS  = 150,
  parameter int DEATH_TICKS = 1000,
  parameter int GAP_TICKS   = 20
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic jump_req,
  input  logic dead_flag,
  output logic jump,
  output logic isdead,
  output logic busy
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    IDLE, JUMP, GAP, DEATH, HOLD
`ifdef SFX_RETRIGGER_EN
    , RETRIG
`endif
  } state_t;

  state_t        state, nxt;
  logic [PW-1:0] presc;
  logic [15:0]   timer, load_val;
  logic          jump_q, dead_q;
  logic          jump_rise, dead_rise, tick, expire;

  assign jump_rise = jump_req & ~jump_q;
  assign dead_rise = dead_flag & ~dead_q;
  assign tick      = (presc == PW'(TICK_DIV - 1));
  // timed states leave on the tick that would take the timer from 1 to 0
  assign expire    = tick && (timer == 16'd1);

  // next-state decision; death always has priority over jump activity
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (dead_rise) nxt = DEATH;
              else if (jump_rise) nxt = JUMP;
      JUMP:   if (dead_rise) nxt = DEATH;
`ifdef SFX_RETRIGGER_EN
              else if (jump_rise) nxt = RETRIG;
`endif
              else if (expire) nxt = GAP;
`ifdef SFX_RETRIGGER_EN
      // one silent cycle so audio_engine restarts from its base pitch
      RETRIG: if (dead_rise) nxt = DEATH;
              else nxt = JUMP;
`endif
      GAP:    if (dead_rise) nxt = DEATH;
              else if (expire) nxt = IDLE;
      DEATH:  if (expire) nxt = HOLD;
      HOLD:   if (!dead_flag) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // tick count loaded on entry to each state (untimed states load 0)
  always_comb begin
    load_val = '0;
    case (nxt)
      JUMP:    load_val = 16'(JUMP_TICKS);
      GAP:     load_val = 16'(GAP_TICKS);
      DEATH:   load_val = 16'(DEATH_TICKS);
      default: load_val = '0;
    endcase
  end

  // state, timebase and registered gate outputs
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state  <= IDLE;
      presc  <= '0;
      timer  <= '0;
      jump_q <= 1'b0;
      dead_q <= 1'b0;
      jump   <= 1'b0;
      isdead <= 1'b0;
      busy   <= 1'b0;
    end else begin
      jump_q <= jump_req;
      dead_q <= dead_flag;
      state  <= nxt;
      // outputs decoded from the next state so they move on the sampling edge
      jump   <= (nxt == JUMP);
      isdead <= (nxt == DEATH);
      busy   <= (nxt != IDLE);
      if (nxt != state) begin
        presc <= '0;
        timer <= load_val;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick && timer != 16'd0) timer <= timer - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with TICK_DIV=4, JUMP_TICKS=3,
// DEATH_TICKS=5, GAP_TICKS=2 (jump 12 cycles, gap 8, death 20).
module tb_sfx_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic jump_req = 1'b0;
  logic dead_flag = 1'b0;
  logic jump, isdead, busy;
  int n_tests = 0;
  int n_fail  = 0;

  sfx_sequencer #(.TICK_DIV(4), .JUMP_TICKS(3), .DEATH_TICKS(5), .GAP_TICKS(2)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .jump_req(jump_req), .dead_flag(dead_flag),
    .jump(jump), .isdead(isdead), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic j, input logic d, input logic b);
    chk({tag, ".jump"}, jump, j);
    chk({tag, ".isdead"}, isdead, d);
    chk({tag, ".busy"}, busy, b);
  endtask

  // advance one edge, sample 1 time unit later, gates never both high
  task automatic step();
    @(posedge clk); #1;
    chk("excl", jump & isdead, 1'b0);
  endtask

  initial begin
    // reset state
    #12; outs("rst", 0, 0, 0);
    rst_n = 1'b1;
    step(); outs("idle", 0, 0, 0);

    // 1: single jump tone, gap, idle
    jump_req = 1'b1; step(); outs("t1.start", 1, 0, 1);
    jump_req = 1'b0;
    for (int i = 1; i < 12; i++) begin step(); outs("t1.tone", 1, 0, 1); end
    for (int i = 0; i < 8; i++) begin step(); outs("t1.gap", 0, 0, 1); end
    step(); outs("t1.idle", 0, 0, 0);

    // 2: jump request on the 5th cycle of a tone
    jump_req = 1'b1; step(); jump_req = 1'b0;
    repeat (3) step();
    jump_req = 1'b1; step(); jump_req = 1'b0;
`ifdef SFX_RETRIGGER_EN
    outs("t2.drop", 0, 0, 1);
    for (int i = 0; i < 12; i++) begin step(); outs("t2.retone", 1, 0, 1); end
`else
    outs("t2.keep", 1, 0, 1);
    for (int i = 0; i < 7; i++) begin step(); outs("t2.tone", 1, 0, 1); end
`endif
    step(); outs("t2.gap", 0, 0, 1);
    repeat (7) step();
    step(); outs("t2.idle", 0, 0, 0);

    // 3: death pre-empts a jump tone on its 6th cycle
    jump_req = 1'b1; step(); jump_req = 1'b0;
    repeat (4) step();
    dead_flag = 1'b1; step(); outs("t3.preempt", 0, 1, 1);
    for (int i = 1; i < 20; i++) begin step(); outs("t3.death", 0, 1, 1); end
    step(); outs("t3.hold", 0, 0, 1);
    for (int i = 0; i < 3; i++) begin step(); outs("t3.hold_stay", 0, 0, 1); end
    dead_flag = 1'b0; step(); outs("t3.idle", 0, 0, 0);

    // 4: simultaneous jump and death rise from idle
    jump_req = 1'b1; dead_flag = 1'b1; step(); outs("t4.death", 0, 1, 1);
    jump_req = 1'b0;
    for (int i = 1; i < 20; i++) begin step(); outs("t4.tone", 0, 1, 1); end
    step(); outs("t4.hold", 0, 0, 1);
    dead_flag = 1'b0; step(); outs("t4.idle", 0, 0, 0);

    // 5a: jump request during gap is dropped
    jump_req = 1'b1; step(); jump_req = 1'b0;
    repeat (11) step();
    step(); outs("t5.gap", 0, 0, 1);
    jump_req = 1'b1; step(); outs("t5.gap_req", 0, 0, 1);
    jump_req = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); outs("t5.gap_rest", 0, 0, 1); end
    step(); outs("t5.idle", 0, 0, 0);

    // 5b: repeated jump requests during death are ignored
    dead_flag = 1'b1; step(); outs("t5.death", 0, 1, 1);
    for (int i = 1; i < 20; i++) begin
      jump_req = i[0];
      step(); outs("t5.death_req", 0, 1, 1);
    end
    jump_req = 1'b0;
    step(); outs("t5.hold", 0, 0, 1);
    step(); outs("t5.hold2", 0, 0, 1);
    dead_flag = 1'b0; step(); outs("t5.idle", 0, 0, 0);

    // 6: async reset mid-death, level still high re-triggers a full tone
    dead_flag = 1'b1; step(); outs("t6.death", 0, 1, 1);
    repeat (8) step();
    step(); outs("t6.pre_rst", 0, 1, 1);
    #1 rst_n = 1'b0;
    #1 outs("t6.async_rst", 0, 0, 0);
    #2 rst_n = 1'b1;
    step(); outs("t6.redeath", 0, 1, 1);
    for (int i = 1; i < 20; i++) begin step(); outs("t6.tone", 0, 1, 1); end
    step(); outs("t6.hold", 0, 0, 1);
    dead_flag = 1'b0; step(); outs("t6.idle", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
